// File: rtl/mips_cpu_divider.sv
// Iterative restoring divider for MIPS DIV/DIVU: one quotient bit per cycle on
// operand magnitudes, with sign correction and divide-by-zero override in a final FIX cycle.
module mips_cpu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic             accept_s;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] quo_r;        // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dsr_r;
  logic [WIDTH-1:0] dvd_r;
  logic             neg_q_r, neg_r_r, div_zero_r;
  logic             busy_r, done_r;
  logic [WIDTH-1:0] quotient_r, remainder_r;
  logic [WIDTH:0]   trial_s, diff_s;
  logic             qbit_s;
  logic [WIDTH-1:0] rem_next_s;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic en);
    if (en && v[WIDTH-1]) magnitude = WIDTH'(0) - v;
    else                  magnitude = v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v, input logic en);
    if (en) cond_negate = WIDTH'(0) - v;
    else    cond_negate = v;
  endfunction

  assign accept_s  = start && ((state_r == IDLE) || (state_r == DONE));
  assign busy      = busy_r;
  assign done      = done_r;
  assign quotient  = quotient_r;
  assign remainder = remainder_r;

  // Next-state decode for the divider sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = CALC;
        else       state_s = IDLE;
      end
      CALC: begin
        if (count_r == LAST_COUNT) state_s = FIX;
        else                       state_s = CALC;
      end
      FIX:     state_s = DONE;
      DONE: begin
        if (start) state_s = CALC;
        else       state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == CALC) || (state_s == FIX);
      done_r  <= (state_s == DONE);
    end
  end

  // One restoring step: compare in WIDTH+1 bits so the shifted partial never overflows.
  always_comb begin
    trial_s    = {rem_r, quo_r[WIDTH-1]};
    diff_s     = trial_s - {1'b0, dsr_r};
    qbit_s     = 1'b0;
    rem_next_s = trial_s[WIDTH-1:0];
    if (trial_s >= {1'b0, dsr_r}) begin
      qbit_s     = 1'b1;
      rem_next_s = diff_s[WIDTH-1:0];
    end else begin
      qbit_s     = 1'b0;
      rem_next_s = trial_s[WIDTH-1:0];
    end
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r     <= '0;
      quo_r       <= '0;
      rem_r       <= '0;
      dsr_r       <= '0;
      dvd_r       <= '0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      div_zero_r  <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
    end else if (accept_s) begin
      count_r    <= '0;
      quo_r      <= magnitude(dividend, is_signed);
      rem_r      <= '0;
      dsr_r      <= magnitude(divisor, is_signed);
      dvd_r      <= dividend;
      neg_q_r    <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r_r    <= is_signed && dividend[WIDTH-1];
      div_zero_r <= (divisor == '0);
    end else if (state_r == CALC) begin
      count_r <= count_r + CW'(1);
      rem_r   <= rem_next_s;
      quo_r   <= {quo_r[WIDTH-2:0], qbit_s};
    end else if (state_r == FIX) begin
      // Divide-by-zero bypasses sign correction: all-ones quotient, raw dividend remainder.
      if (div_zero_r) begin
        quotient_r  <= '1;
        remainder_r <= dvd_r;
      end else begin
        quotient_r  <= cond_negate(quo_r, neg_q_r);
        remainder_r <= cond_negate(rem_r, neg_r_r);
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule
